// File: rtl/monitor_mux_sequencer_if.sv
// Control, mux-select and ADC handshake bundle for the monitor mux sequencer.
interface monitor_mux_sequencer_if #(
  parameter int N_CH     = 40,
  parameter int SETTLE_W = 8,
  parameter int ADC_W    = 12
);
  localparam int CW = $clog2(N_CH);

  logic                Start;
  logic                Abort;
  logic                ScanEn;
  logic                Continuous;
  logic [CW-1:0]       ChLo;
  logic [CW-1:0]       ChHi;
  logic [SETTLE_W-1:0] SettleCycles;
  logic                AdcDone;
  logic [ADC_W-1:0]    AdcData;
  logic [N_CH-1:0]     Select;
  logic                AdcStart;
  logic [ADC_W-1:0]    DataOut;
  logic [CW-1:0]       ChOut;
  logic                DataValid;
  logic                Busy;
  logic                Timeout;
  logic                CfgErr;

  modport master (
    output Start, Abort, ScanEn, Continuous,
    output ChLo, ChHi, SettleCycles,
    output AdcDone, AdcData,
    input  Select, AdcStart, DataOut, ChOut,
    input  DataValid, Busy, Timeout, CfgErr
  );

  modport slave (
    input  Start, Abort, ScanEn, Continuous,
    input  ChLo, ChHi, SettleCycles,
    input  AdcDone, AdcData,
    output Select, AdcStart, DataOut, ChOut,
    output DataValid, Busy, Timeout, CfgErr
  );
endinterface

// File: rtl/monitor_mux_sequencer.sv
// Steps an analog mux over a channel range, settles, triggers the ADC
// and tags each result with its channel.
module monitor_mux_sequencer #(
  parameter int N_CH     = 40,
  parameter int SETTLE_W = 8,
  parameter int ADC_W    = 12,
  parameter int TMO_W    = 10
) (
  input logic                    Clk,
  input logic                    Reset,
  monitor_mux_sequencer_if.slave bus
);
  localparam int CW = $clog2(N_CH);
  localparam logic [CW:0] NCH = (CW+1)'(N_CH);
  // Last count value before the limit; the exit edge lands on the limit.
  localparam logic [TMO_W-1:0] TMO_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    BREAK
  } state_t;

  state_t              state;
  logic [CW-1:0]       lo;
  logic [CW-1:0]       hi;
  logic [CW-1:0]       ch;
  logic [CW-1:0]       chout;
  logic [CW-1:0]       nxt;
  logic                scan;
  logic                cont;
  logic [SETTLE_W-1:0] settle;
  logic [SETTLE_W-1:0] cnt;
  logic [TMO_W-1:0]    tmo;
  logic [N_CH-1:0]     select;
  logic [ADC_W-1:0]    dataout;
  logic                adcstart;
  logic                datavalid;
  logic                busy;
  logic                timeout;
  logic                cfgerr;
  logic                cfg_bad;
  logic                done_ok;
  logic                tmo_hit;
  logic                last;

  function automatic logic [N_CH-1:0] onehot(
    input logic [CW-1:0] c
  );
    return {{(N_CH-1){1'b0}}, 1'b1} << c;
  endfunction

  always_comb begin
    cfg_bad = ({1'b0, bus.ChLo} >= NCH) ||
              (bus.ScanEn &&
               (({1'b0, bus.ChHi} >= NCH) ||
                (bus.ChHi < bus.ChLo)));
    // AdcStart is high exactly on the first CONVERT cycle.
    done_ok = bus.AdcDone && !adcstart;
    tmo_hit = (tmo == TMO_LAST);
    last    = !scan || ((ch == hi) && !cont);
    nxt     = (ch == hi) ? lo : ch + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      ch        <= '0;
      chout     <= '0;
      scan      <= 1'b0;
      cont      <= 1'b0;
      settle    <= '0;
      cnt       <= '0;
      tmo       <= '0;
      select    <= '0;
      dataout   <= '0;
      adcstart  <= 1'b0;
      datavalid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      cfgerr    <= 1'b0;
    end else begin
      adcstart  <= 1'b0;
      datavalid <= 1'b0;
      timeout   <= 1'b0;
      cfgerr    <= 1'b0;
      if (bus.Abort) begin
        state  <= IDLE;
        select <= '0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.Start) begin
              if (cfg_bad) begin
                cfgerr <= 1'b1;
              end else begin
                lo     <= bus.ChLo;
                hi     <= bus.ChHi;
                scan   <= bus.ScanEn;
                cont   <= bus.Continuous;
                settle <= bus.SettleCycles;
                ch     <= bus.ChLo;
                cnt    <= bus.SettleCycles;
                select <= onehot(bus.ChLo);
                busy   <= 1'b1;
                state  <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              state    <= CONVERT;
              adcstart <= 1'b1;
              tmo      <= '0;
            end else begin
              cnt <= cnt - SETTLE_W'(1);
            end
          end
          CONVERT: begin
            if (done_ok || tmo_hit) begin
              if (done_ok) begin
                datavalid <= 1'b1;
                dataout   <= bus.AdcData;
                chout     <= ch;
              end else begin
                timeout <= 1'b1;
              end
              select <= '0;
              if (last) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= BREAK;
              end
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end
          BREAK: begin
            ch     <= nxt;
            cnt    <= settle;
            select <= onehot(nxt);
            state  <= SETTLE;
          end
        endcase
      end
    end
  end

  assign bus.Select    = select;
  assign bus.AdcStart  = adcstart;
  assign bus.DataOut   = dataout;
  assign bus.ChOut     = chout;
  assign bus.DataValid = datavalid;
  assign bus.Busy      = busy;
  assign bus.Timeout   = timeout;
  assign bus.CfgErr    = cfgerr;
endmodule

// File: tb/tb_monitor_mux_sequencer.sv
// Randomized scoreboard bench for monitor_mux_sequencer with an ADC
// responder and a channel-order reference model.
module tb_monitor_mux_sequencer;
  localparam int N_CH     = 40;
  localparam int SETTLE_W = 8;
  localparam int ADC_W    = 12;
  localparam int TMO_W    = 4;
  localparam int CW       = $clog2(N_CH);
  localparam int TMO_CYC  = (1 << TMO_W) - 1;
  localparam int K_DATA   = 0;
  localparam int K_TMO    = 1;
  localparam int K_CFG    = 2;

  typedef struct {
    int kind;
    int ch;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   npass = 0;
  int   ntotal = 0;
  exp_t sb[$];
  int   last_d = 0;
  int   last_c = 0;
  int   gap = 0;

  monitor_mux_sequencer_if #(
    .N_CH(N_CH), .SETTLE_W(SETTLE_W), .ADC_W(ADC_W)
  ) bus ();

  monitor_mux_sequencer #(
    .N_CH(N_CH), .SETTLE_W(SETTLE_W),
    .ADC_W(ADC_W), .TMO_W(TMO_W)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  function automatic logic [N_CH-1:0] one(input int c);
    logic [N_CH-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic pop(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      ntotal++;
      $display("FAIL unexpected_event: got kind %0d required none", kind);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == K_DATA && kind == K_DATA) begin
        chk("data_out", bus.DataOut, e.data);
        chk("ch_out", bus.ChOut, e.ch);
        last_d = e.data;
        last_c = e.ch;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_d = 0;
        last_c = 0;
        gap = 0;
      end else begin
        if (bus.DataValid) pop(K_DATA);
        if (bus.Timeout) pop(K_TMO);
        if (bus.CfgErr) pop(K_CFG);
        chk("data_hold", bus.DataOut, last_d);
        chk("ch_hold", bus.ChOut, last_c);
        chk("select_onehot", $countones(bus.Select) <= 1, 1);
        if (!bus.Busy) chk("idle_select", bus.Select, 0);
        if (bus.Busy && bus.Select == '0) gap++;
        else begin
          if (gap != 0) chk("break_len", gap, 1);
          gap = 0;
        end
      end
    end
  end

  task automatic chk_reset_outs();
    chk("rst_select", bus.Select, 0);
    chk("rst_adcstart", bus.AdcStart, 0);
    chk("rst_dataout", bus.DataOut, 0);
    chk("rst_chout", bus.ChOut, 0);
    chk("rst_datavalid", bus.DataValid, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_timeout", bus.Timeout, 0);
    chk("rst_cfgerr", bus.CfgErr, 0);
  endtask

  task automatic run_seq(
    input int lo, input int hi, input bit scan, input bit cont,
    input int s, input int abidx, input int fixd,
    output int first_as, output int dvi, output int iend
  );
    bit bad;
    bit done;
    int k;
    int i;
    int n;
    bad = (lo >= N_CH) || (scan && (hi >= N_CH || hi < lo));
    n = scan ? hi - lo + 1 : 1;
    k = 0;
    done = 0;
    first_as = -1;
    dvi = -1;
    i = 1;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.ChLo = CW'(lo);
    bus.ChHi = CW'(hi);
    bus.ScanEn = scan;
    bus.Continuous = cont;
    bus.SettleCycles = SETTLE_W'(s);
    if (bad) sb.push_back(exp_t'{K_CFG, 0, 0});
    @(negedge clk);
    bus.Start = 1'b0;
    bus.ChLo = CW'($urandom);
    bus.ChHi = CW'($urandom);
    bus.ScanEn = 1'($urandom);
    bus.Continuous = 1'($urandom);
    bus.SettleCycles = SETTLE_W'($urandom);
    if (bad) begin
      chk("cfgerr_pulse", bus.CfgErr, 1);
      repeat (3) begin
        chk("cfg_busy", bus.Busy, 0);
        chk("cfg_select", bus.Select, 0);
        @(negedge clk);
      end
    end else begin
      fork
        begin
          chk("first_select", bus.Select, one(lo));
          chk("busy_rise", bus.Busy, 1);
          while (bus.Busy && i < 4000) begin
            @(negedge clk);
            i++;
            bus.Start = (i == 2) ? 1'($urandom) : 1'b0;
            if (bus.AdcStart && first_as < 0) first_as = i;
            if (bus.DataValid && dvi < 0) dvi = i;
          end
          bus.Start = 1'b0;
          chk("busy_bound", i < 4000, 1);
          done = 1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            if (bus.AdcStart) begin
              int d;
              int ech;
              int at;
              bit ab;
              bit spur;
              bit hold2;
              logic [ADC_W-1:0] dat;
              ech = scan ? lo + (k % n) : lo;
              chk("select_at_adcstart", bus.Select, one(ech));
              ab = (k == abidx);
              d = (fixd > 0) ? fixd : int'($urandom_range(1, 17));
              if (ab && d >= TMO_CYC) d = TMO_CYC - 1;
              spur = (fixd == 0) && (d >= 2) &&
                     ($urandom_range(0, 3) == 0);
              hold2 = !ab && (fixd == 0) &&
                      ($urandom_range(0, 3) == 0);
              dat = ADC_W'($urandom);
              k++;
              at = 0;
              if (spur) begin
                bus.AdcDone = 1'b1;
                bus.AdcData = ~dat;
                @(negedge clk);
                bus.AdcDone = 1'b0;
                at = 1;
              end
              if (d >= TMO_CYC) begin
                sb.push_back(exp_t'{K_TMO, ech, 0});
                repeat (TMO_CYC - at) @(negedge clk);
                chk("timeout_pulse", bus.Timeout, 1);
              end else begin
                repeat (d - at) @(negedge clk);
                bus.AdcDone = 1'b1;
                bus.AdcData = dat;
                if (ab) bus.Abort = 1'b1;
                else sb.push_back(exp_t'{K_DATA, ech, int'(dat)});
                @(negedge clk);
                bus.AdcDone = hold2;
                bus.Abort = 1'b0;
                if (ab) begin
                  chk("abort_busy", bus.Busy, 0);
                  chk("abort_select", bus.Select, 0);
                  chk("abort_no_valid", bus.DataValid, 0);
                end else begin
                  chk("valid_latency", bus.DataValid, 1);
                end
                if (hold2) begin
                  bus.AdcData = ~dat;
                  @(negedge clk);
                  bus.AdcDone = 1'b0;
                end
              end
            end
          end
        end
      join
      chk("first_adcstart", first_as, s + 2);
      chk("adcstart_count", k, (abidx >= 0) ? abidx + 1 : n);
    end
    iend = i;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int fa;
    int dv;
    int ie;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.ScanEn = 1'b0;
    bus.Continuous = 1'b0;
    bus.ChLo = '0;
    bus.ChHi = '0;
    bus.SettleCycles = '0;
    bus.AdcDone = 1'b0;
    bus.AdcData = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    @(negedge clk);

    run_seq(5, 0, 0, 0, 3, -1, 3, fa, dv, ie);
    chk("single_datavalid_cyc", dv, 9);
    chk("single_busy_fall_cyc", ie, 9);
    run_seq(38, 39, 1, 0, 0, -1, 2, fa, dv, ie);
    chk("scan_first_valid_cyc", dv, 5);
    run_seq(0, 2, 1, 1, 1, 4, 0, fa, dv, ie);
    run_seq(10, 10, 0, 0, 2, -1, 16, fa, dv, ie);
    chk("tmo_no_valid", dv, -1);
    chk("tmo_end_cyc", ie, 19);
    run_seq(3, 4, 1, 0, 0, -1, 16, fa, dv, ie);
    run_seq(20, 20, 0, 0, 0, -1, 14, fa, dv, ie);
    chk("last_cycle_done_cyc", dv, 17);
    run_seq(40, 0, 0, 0, 0, -1, 0, fa, dv, ie);
    run_seq(7, 3, 1, 0, 0, -1, 0, fa, dv, ie);
    run_seq(39, 40, 1, 0, 0, -1, 0, fa, dv, ie);

    @(negedge clk);
    bus.ChLo = CW'(2);
    bus.ScanEn = 1'b0;
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    chk("start_abort_busy", bus.Busy, 0);
    chk("start_abort_select", bus.Select, 0);

    @(negedge clk);
    bus.ChLo = CW'(9);
    bus.SettleCycles = SETTLE_W'(20);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", bus.Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b0;
    run_seq(9, 11, 1, 0, 2, -1, 0, fa, dv, ie);

    for (int t = 0; t < 30; t++) begin
      int lo;
      int hi;
      int ab;
      int n;
      bit sc;
      bit co;
      sc = 1'($urandom);
      co = 1'($urandom);
      lo = $urandom_range(0, N_CH - 1);
      hi = $urandom_range(lo, (lo + 3 > N_CH - 1) ? N_CH - 1 : lo + 3);
      if ($urandom_range(0, 7) == 0) lo = $urandom_range(N_CH, 63);
      else if (sc && lo > 0 && $urandom_range(0, 7) == 0)
        hi = $urandom_range(0, lo - 1);
      n = sc ? hi - lo + 1 : 1;
      ab = -1;
      if (sc && co) ab = $urandom_range(0, 2 * n);
      else if ($urandom_range(0, 3) == 0 && n > 0)
        ab = $urandom_range(0, n - 1);
      run_seq(lo, hi, sc, co, $urandom_range(0, 5), ab, 0,
              fa, dv, ie);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
